// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and the queued entry layout for the ALU result buffer.
package alu_pkg;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned ENTRY_W = WIDTH + 3 + 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef struct packed {
    logic [2:0]       opp;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } entry_t;

  // Logic ops leave carry/overflow undriven on the ALU, so they are forced to 0 here.
  function automatic entry_t build_entry(input logic [2:0] opp, input logic [WIDTH-1:0] result,
                                         input logic carry, input logic overflow);
    entry_t e;
    logic   arith;
    arith      = (opp == OP_ADD) || (opp == OP_SUB);
    e.opp      = opp;
    e.result   = result;
    e.carry    = arith ? carry : 1'b0;
    e.overflow = arith ? overflow : 1'b0;
    e.zero     = (result == WIDTH'(0));
    return e;
  endfunction

endpackage

// File: rtl/alu_result_buffer_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter so full and empty never alias.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is cleared on reset so the head data reads as zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/alu_result_buffer.sv
// Registered stage behind the 4-bit ALU: decodes opcode, masks flags, queues results, keeps sticky status.
module alu_result_buffer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opp,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_opp,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic             sticky_err,
  output logic [AW:0]      level
);

  logic   accept;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  entry_t wr_entry;
  entry_t head;
  logic [ENTRY_W-1:0] rdata;

  // Opcodes 1xx are consumed from the ALU but never stored.
  assign accept   = in_valid && in_ready;
  assign push     = accept && !in_opp[2];
  assign pop      = out_valid && out_ready;
  assign wr_entry = build_entry(in_opp, in_result, in_carry, in_overflow);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign head         = rdata;
  assign in_ready     = !full;
  assign out_valid    = !empty;
  assign out_opp      = head.opp;
  assign out_result   = head.result;
  assign out_carry    = head.carry;
  assign out_overflow = head.overflow;
  assign out_zero     = head.zero;

  // Set conditions take priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_ovf <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      if (push && wr_entry.overflow) sticky_ovf <= 1'b1;
      else if (clr_sticky)           sticky_ovf <= 1'b0;
      if (accept && in_opp[2])       sticky_err <= 1'b1;
      else if (clr_sticky)           sticky_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  typedef struct {
    logic [2:0] opp;
    logic [3:0] res;
    logic       c;
    logic       ov;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_opp = 3'd0;
  logic [3:0] in_result = 4'd0;
  logic       in_carry = 1'b0;
  logic       in_overflow = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_opp;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_overflow;
  logic       out_zero;
  logic       clr_sticky = 1'b0;
  logic       sticky_ovf;
  logic       sticky_err;
  logic [2:0] level;

  int n_chk = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  ent_t q[$];
  bit   m_ovf = 1'b0;
  bit   m_err = 1'b0;

  alu_result_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opp(in_opp), .in_result(in_result), .in_carry(in_carry), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_opp(out_opp), .out_result(out_result),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_err(sticky_err), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus two sticky bits, updated from the rules directly.
  always @(posedge clk) begin
    bit   acc, pp, set_o, set_e;
    ent_t e;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      acc   = (in_valid === 1'b1) && (q.size() < D);
      pp    = (q.size() > 0) && (out_ready === 1'b1);
      set_o = 1'b0;
      set_e = 1'b0;
      if (pp) void'(q.pop_front());
      if (acc) begin
        if (in_opp >= 3'd4) set_e = 1'b1;
        else begin
          e.opp = in_opp;
          e.res = in_result;
          e.c   = (in_opp <= 3'd1) ? in_carry : 1'b0;
          e.ov  = (in_opp <= 3'd1) ? in_overflow : 1'b0;
          q.push_back(e);
          set_o = e.ov;
        end
      end
      if (set_o) m_ovf = 1'b1; else if (clr_sticky) m_ovf = 1'b0;
      if (set_e) m_err = 1'b1; else if (clr_sticky) m_err = 1'b0;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("in_ready",   32'(in_ready),   32'(q.size() != D));
      chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
      chk("level",      32'(level),      32'(q.size()));
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_ovf));
      chk("sticky_err", 32'(sticky_err), 32'(m_err));
      if (q.size() != 0) begin
        chk("out_opp",      32'(out_opp),      32'(q[0].opp));
        chk("out_result",   32'(out_result),   32'(q[0].res));
        chk("out_carry",    32'(out_carry),    32'(q[0].c));
        chk("out_overflow", 32'(out_overflow), 32'(q[0].ov));
        chk("out_zero",     32'(out_zero),     32'(q[0].res == 4'd0));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] r,
                       input logic c, input logic ov);
    in_valid = v; in_opp = op; in_result = r; in_carry = c; in_overflow = ov;
  endtask

  initial begin
    // 1: reset for two cycles
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    run_cmp = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_stickies", 32'({sticky_ovf, sticky_err}), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);

    // 2: single ADD with zero result
    drive(1, 3'b000, 4'h0, 1, 0);
    tick();
    drive(0, 3'b000, 4'h0, 0, 0);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_result", 32'(out_result), 32'd0);
    chk("t2_zero", 32'(out_zero), 32'd1);
    chk("t2_carry", 32'(out_carry), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_popped", 32'(out_valid), 32'd0);

    // 3: fill, hold a fifth, pop once, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'b001, 4'(i), 0, 0);
      tick();
    end
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_full_level", 32'(level), 32'd4);
    drive(1, 3'b000, 4'h5, 0, 0);
    tick();
    chk("t3_hold_level", 32'(level), 32'd4);
    chk("t3_hold_head", 32'(out_result), 32'd1);
    out_ready = 1'b1;
    tick();
    drive(0, 3'b000, 4'h0, 0, 0);
    out_ready = 1'b0;
    chk("t3_pop_ready", 32'(in_ready), 32'd1);
    chk("t3_pop_level", 32'(level), 32'd3);
    for (int k = 2; k <= 4; k++) begin
      chk("t3_drain", 32'(out_result), 32'(k));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty", 32'(out_valid), 32'd0);

    // 4: AND masks carry and overflow
    drive(1, 3'b010, 4'hA, 1, 1);
    tick();
    drive(0, 3'b000, 4'h0, 0, 0);
    chk("t4_carry", 32'(out_carry), 32'd0);
    chk("t4_ovf", 32'(out_overflow), 32'd0);
    chk("t4_zero", 32'(out_zero), 32'd0);
    chk("t4_result", 32'(out_result), 32'hA);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5: illegal opcode dropped; set beats clear
    drive(1, 3'b101, 4'h7, 1, 1);
    tick();
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_err", 32'(sticky_err), 32'd1);
    drive(1, 3'b001, 4'h3, 0, 1);
    clr_sticky = 1'b1;
    tick();
    drive(0, 3'b000, 4'h0, 0, 0);
    clr_sticky = 1'b0;
    chk("t5_ovf", 32'(sticky_ovf), 32'd1);
    chk("t5_err_clr", 32'(sticky_err), 32'd0);
    chk("t5_head_ovf", 32'(out_overflow), 32'd1);

    // 6: reset mid-traffic, then simultaneous push/pop at level 2
    drive(1, 3'b000, 4'h9, 0, 0);
    tick(); tick();
    drive(0, 3'b000, 4'h0, 0, 0);
    chk("t6_level3", 32'(level), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    drive(1, 3'b011, 4'h6, 0, 0);
    tick(); tick();
    out_ready = 1'b1;
    drive(1, 3'b000, 4'hF, 1, 1);
    tick();
    drive(0, 3'b000, 4'h0, 0, 0);
    out_ready = 1'b0;
    chk("t6_pp_level", 32'(level), 32'd2);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      drive(1'($urandom_range(0, 99) < 60), 3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      out_ready  = 1'($urandom_range(0, 99) < 50);
      clr_sticky = 1'($urandom_range(0, 99) < 5);
      reset      = 1'($urandom_range(0, 999) < 3);
      tick();
    end
    reset = 1'b0;
    drive(0, 3'b000, 4'h0, 0, 0);
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
